mod_inv: RTL and testbench

Sequential modular inverter: given operand a and a modulus select, returns a⁻¹ mod q. It computes a^(q−2) mod q (Fermat) by left-to-right square-and-multiply over one time-shared `mod_mul` instance. It is the inverse-direction companion of `mod_mul` in the PE arithmetic datapath.

- select = 1: Kyber, q = 3329.
- select = 0: Dilithium, q = 8380417.

---
 rtl/mod_pkg.sv | 20 ++
 rtl/mod_mul.sv | 24 ++
 rtl/mod_inv.sv | 116 +++++++++++
 tb/tb_mod_inv.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared constants and state type for the modular arithmetic datapath.
package mod_pkg;

    localparam int unsigned W     = 23;
    localparam int unsigned KW    = 12;
    localparam int unsigned IDX_W = 5;

    localparam logic [W-1:0]  Q_KYBER   = 23'd3329;
    localparam logic [W-1:0]  Q_DIL     = 23'd8380417;
    localparam logic [KW-1:0] EXP_KYBER = 12'hCFF;
    localparam logic [W-1:0]  EXP_DIL   = 23'h7FDFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } inv_state_t;

endpackage

// File: rtl/mod_mul.sv
// Combinational modular multiplier: c = a*b mod q, q chosen by select (1 = Kyber).
module mod_mul
    import mod_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         select_i,
    output logic [W-1:0] c_o
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] prod;
    logic [PW-1:0] q;
    logic [PW-1:0] rem;

    always_comb begin
        prod = PW'(a_i) * PW'(b_i);
        q    = select_i ? PW'(Q_KYBER) : PW'(Q_DIL);
        rem  = prod % q;
        c_o  = W'(rem);
    end

endmodule

// File: rtl/mod_inv.sv
// Sequential modular inverter: c = a^(q-2) mod q via left-to-right square-and-multiply
// over one shared mod_mul.
module mod_inv
    import mod_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic         select_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] c_o
);

    inv_state_t       state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     r_q, r_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sel_q, sel_d;
    logic [W-1:0]     c_d;
    logic             done_d;
    logic             busy_d;

    logic [W-1:0]     mul_b;
    logic [W-1:0]     mul_c;
    logic [W-1:0]     exp_word;
    logic             exp_bit;

    mod_mul u_mod_mul (
        .a_i      (r_q),
        .b_i      (mul_b),
        .select_i (sel_q),
        .c_o      (mul_c)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            a_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            c_o     <= '0;
            done_o  <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            c_o     <= c_d;
            done_o  <= done_d;
            busy_o  <= busy_d;
        end
    end

    // Next-state and datapath; the final product is written to c_o as DONE is entered.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        r_d      = r_q;
        idx_d    = idx_q;
        sel_d    = sel_q;
        c_d      = c_o;
        done_d   = 1'b0;
        mul_b    = (state_q == MUL) ? a_q : r_q;
        exp_word = sel_q ? W'(EXP_KYBER) : EXP_DIL;
        exp_bit  = exp_word[idx_q];

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = select_i ? W'(a_i[KW-1:0]) : a_i;
                    sel_d   = select_i;
                    r_d     = W'(1);
                    idx_d   = select_i ? IDX_W'(KW - 1) : IDX_W'(W - 1);
                    state_d = SQR;
                end
            end
            SQR: begin
                r_d = mul_c;
                if (exp_bit) begin
                    state_d = MUL;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    c_d     = mul_c;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            MUL: begin
                r_d = mul_c;
                if (idx_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    c_d     = mul_c;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = SQR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mod_inv.sv
// Directed and scoreboard bench for mod_inv (Kyber and Dilithium inverses).
module tb_mod_inv;

    localparam int unsigned Q_K = 3329;
    localparam int unsigned Q_D = 8380417;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [22:0] a_i;
    logic        select_i;
    logic        busy_o;
    logic        done_o;
    logic [22:0] c_o;

    int total = 0;
    int bad   = 0;

    mod_inv dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .a_i      (a_i),
        .select_i (select_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .c_o      (c_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One request: start sampled at E0, then wait (bounded) for done_o.
    task automatic do_op(input logic [22:0] a, input logic sel,
                         output logic [22:0] c, output int lat);
        a_i      = a;
        select_i = sel;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        c = c_o;
        @(posedge clk_i);
        #1;
        check("done_width", 32'(done_o), 32'd0);
        check("busy_after", 32'(busy_o), 32'd0);
    endtask

    task automatic run(input string tag, input logic [22:0] a, input logic sel,
                       input logic [22:0] exp_c, input int exp_lat);
        logic [22:0] c;
        int lat;
        do_op(a, sel, c, lat);
        check({tag, "_c"}, 32'(c), 32'(exp_c));
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        logic [22:0] c;
        int          lat;
        longint      prod;
        int          ra;
        int          last_done;
        int          pulses;
        int          gap_bad;
        int          c_bad;

        rst_ni   = 1'b0;
        start_i  = 1'b0;
        a_i      = '0;
        select_i = 1'b0;
        #12;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_c", 32'(c_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Kyber and Dilithium directed vectors
        run("k1", 23'd1, 1'b1, 23'd1, 22);
        run("k2", 23'd2, 1'b1, 23'd1665, 22);
        run("k17", 23'd17, 1'b1, 23'd1175, 22);
        run("k3328", 23'd3328, 1'b1, 23'd3328, 22);
        run("d2", 23'd2, 1'b0, 23'd4190209, 45);
        run("dmax", 23'd8380416, 1'b0, 23'd8380416, 45);
        run("k0", 23'd0, 1'b1, 23'd0, 22);
        run("d0", 23'd0, 1'b0, 23'd0, 45);
        run("kmask", 23'h7FF002, 1'b1, 23'd1665, 22);

        // Inputs changing during a run must not affect the in-flight result
        a_i      = 23'd2;
        select_i = 1'b1;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        lat = 0;
        while (!done_o && lat < 100) begin
            a_i      = 23'd17;
            select_i = ~select_i;
            @(posedge clk_i);
            #1;
            lat++;
        end
        check("chg_c", 32'(c_o), 32'd1665);
        check("chg_lat", 32'(lat), 32'd22);
        @(posedge clk_i);
        #1;

        // start held high: done_o every 24 cycles, c_o stable between pulses
        a_i       = 23'd2;
        select_i  = 1'b1;
        start_i   = 1'b1;
        last_done = -1;
        pulses    = 0;
        gap_bad   = 0;
        c_bad     = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk_i);
            #1;
            if (done_o) begin
                if (last_done >= 0 && cyc - last_done != 24) gap_bad++;
                last_done = cyc;
                pulses++;
            end
            if (pulses > 0 && c_o != 23'd1665) c_bad++;
        end
        start_i = 1'b0;
        check("held_pulses", 32'(pulses), 32'd4);
        check("held_gap", 32'(gap_bad), 32'd0);
        check("held_c", 32'(c_bad), 32'd0);
        lat = 0;
        while (busy_o && lat < 100) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        check("held_idle", 32'(busy_o), 32'd0);

        // Reset mid-op during a Dilithium run
        a_i      = 23'd2;
        select_i = 1'b0;
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        check("mid_rst_c", 32'(c_o), 32'd0);
        pulses = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk_i);
            #1;
            if (done_o) pulses++;
        end
        check("mid_rst_nodone", 32'(pulses), 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        run("post_rst", 23'd2, 1'b1, 23'd1665, 22);

        // Mode switch back to back
        run("sw_k", 23'd17, 1'b1, 23'd1175, 22);
        run("sw_d", 23'd2, 1'b0, 23'd4190209, 45);

        // Scoreboard: c*a mod q == 1 for random nonzero a
        for (int i = 0; i < 200; i++) begin
            ra = int'($urandom_range(Q_K - 1, 1));
            do_op(23'(ra), 1'b1, c, lat);
            prod = (longint'(c) * longint'(ra)) % longint'(Q_K);
            check("rnd_k", 32'(prod), 32'd1);
        end
        for (int i = 0; i < 200; i++) begin
            ra = int'($urandom_range(Q_D - 1, 1));
            do_op(23'(ra), 1'b0, c, lat);
            prod = (longint'(c) * longint'(ra)) % longint'(Q_D);
            check("rnd_d", 32'(prod), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
